// File: rtl/pc_next_unit.sv
// Program-counter unit: N-way next-PC select, PC register, exception entry/return FSM.
// Define PCNEXT_ALIGN_CHECK_EN to trap taken loads whose target has nonzero bits [1:0].
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter int               NUM_SRC      = 4,
  parameter int               SEL_W        = 2,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_true,
  input  logic                     exc_req,
  input  logic [1:0]               exc_cause,
  input  logic                     eret,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         pc_next,
  output logic [WIDTH-1:0]         epc,
  output logic [1:0]               cause,
  output logic                     exc_ack,
  output logic                     in_handler,
  output logic                     double_fault,
  output logic                     misalign
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_EXC_ENTRY = 2'd1;
  localparam logic [1:0] ST_HANDLER   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [1:0]       r_cause;
  logic             r_double_fault;

  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_exc_target;
  logic             w_misalign;
  logic             w_load;
  logic             w_trap;

  // Out-of-range selects fall back to source 0.
  always_comb begin
    // NOTE: default assignment first so every path drives w_pc_next and no latch is inferred.
    w_pc_next = src_data[0 +: WIDTH];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (int'(src_sel) == k) w_pc_next = src_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef PCNEXT_ALIGN_CHECK_EN
  assign w_misalign = |w_pc_next[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_load       = pc_write | (pc_write_cond & cond_true);
  assign w_trap       = exc_req | (w_load & w_misalign);
  assign w_exc_target = EXC_VECTOR + WIDTH'({r_cause, 2'b00});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_pc           <= RESET_VECTOR;
      r_epc          <= '0;
      r_cause        <= 2'b00;
      r_double_fault <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so r_epc <= r_pc captures the PC from before this edge.
      case (r_state)
        ST_RUN: begin
          if (w_trap) begin
            r_epc   <= r_pc;
            r_cause <= exc_req ? exc_cause : 2'b11;
            r_state <= ST_EXC_ENTRY;
          end else if (w_load) begin
            r_pc <= w_pc_next;
          end
        end
        ST_EXC_ENTRY: begin
          r_pc    <= w_exc_target;
          r_state <= ST_HANDLER;
        end
        ST_HANDLER: begin
          // A fault inside the handler re-enters at the base vector and keeps epc/cause.
          if (w_trap) begin
            r_double_fault <= 1'b1;
            r_pc           <= EXC_VECTOR;
          end else if (eret) begin
            r_pc    <= r_epc;
            r_state <= ST_RUN;
          end else if (w_load) begin
            r_pc <= w_pc_next;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign pc           = r_pc;
  assign pc_next      = w_pc_next;
  assign epc          = r_epc;
  assign cause        = r_cause;
  assign exc_ack      = (r_state == ST_EXC_ENTRY);
  assign in_handler   = (r_state == ST_HANDLER);
  assign double_fault = r_double_fault;
  assign misalign     = w_misalign;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: expectations are queued with each stimulus cycle
// and drained after the following clock edge.
module tb_pc_next_unit;
  localparam int W = 32;

  typedef enum int {S_PC, S_EPC, S_CAUSE, S_ACK, S_HND, S_DF, S_NEXT, S_MIS, S_NEXT3} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   src_sel = 2'd0;
  logic [4*W-1:0] src_data;
  logic         pc_write = 1'b0;
  logic         pc_write_cond = 1'b0;
  logic         cond_true = 1'b0;
  logic         exc_req = 1'b0;
  logic [1:0]   exc_cause = 2'd0;
  logic         eret = 1'b0;
  logic [W-1:0] pc, pc_next, epc;
  logic [1:0]   cause;
  logic         exc_ack, in_handler, double_fault, misalign;

  logic [1:0]   src_sel3 = 2'd0;
  logic [3*W-1:0] src_data3;
  logic [W-1:0] pc3, pc_next3, epc3;
  logic [1:0]   cause3;
  logic         exc_ack3, in_handler3, double_fault3, misalign3;

  pc_next_unit #(.WIDTH(W), .NUM_SRC(4), .SEL_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel), .src_data(src_data),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_true(cond_true),
    .exc_req(exc_req), .exc_cause(exc_cause), .eret(eret),
    .pc(pc), .pc_next(pc_next), .epc(epc), .cause(cause), .exc_ack(exc_ack),
    .in_handler(in_handler), .double_fault(double_fault), .misalign(misalign)
  );

  pc_next_unit #(.WIDTH(W), .NUM_SRC(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset_n(reset_n), .src_sel(src_sel3), .src_data(src_data3),
    .pc_write(1'b0), .pc_write_cond(1'b0), .cond_true(1'b0),
    .exc_req(1'b0), .exc_cause(2'b00), .eret(1'b0),
    .pc(pc3), .pc_next(pc_next3), .epc(epc3), .cause(cause3), .exc_ack(exc_ack3),
    .in_handler(in_handler3), .double_fault(double_fault3), .misalign(misalign3)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_PC:    return pc;
      S_EPC:   return epc;
      S_CAUSE: return {30'b0, cause};
      S_ACK:   return {31'b0, exc_ack};
      S_HND:   return {31'b0, in_handler};
      S_DF:    return {31'b0, double_fault};
      S_NEXT:  return pc_next;
      S_MIS:   return {31'b0, misalign};
      S_NEXT3: return pc_next3;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(string n, sig_e s, logic [31:0] v);
    sb.push_back('{name: n, sig: s, val: v});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0;
    exc_req = 1'b0; exc_cause = 2'd0; eret = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          reset_n = 1'b0; src_sel = 2'd2;
          push("rst_pc", S_PC, 32'h0);       push("rst_epc", S_EPC, 32'h0);
          push("rst_cause", S_CAUSE, 32'h0); push("rst_ack", S_ACK, 32'h0);
          push("rst_hnd", S_HND, 32'h0);     push("rst_df", S_DF, 32'h0);
          push("rst_next_comb", S_NEXT, 32'h300);
        end
        default: begin
          reset_n = 1'b1;
          push("post_rst_pc", S_PC, 32'h0);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
  endtask

  task automatic test_load();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          src_sel = 2'd2; pc_write = 1'b1;
          push("load_mis_aligned", S_MIS, 32'h0);
          push("load_pc", S_PC, 32'h300); push("load_no_ack", S_ACK, 32'h0);
        end
        default: begin
          pc_write = 1'b0; src_sel = 2'd0;
          push("load_hold_pc", S_PC, 32'h300);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
  endtask

  task automatic test_branch();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          src_sel = 2'd1; pc_write_cond = 1'b1; cond_true = 1'b0;
          push("br_not_taken_pc", S_PC, 32'h300);
        end
        1: begin
          cond_true = 1'b1;
          push("br_taken_pc", S_PC, 32'h200);
        end
        default: begin
          clear_ctrl(); src_sel = 2'd2; pc_write = 1'b1;
          push("br_restore_pc", S_PC, 32'h300);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
    clear_ctrl();
  endtask

  task automatic test_exception();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin
          exc_req = 1'b1; exc_cause = 2'd2;
          push("exc_ack", S_ACK, 32'h1);     push("exc_epc", S_EPC, 32'h300);
          push("exc_cause", S_CAUSE, 32'h2); push("exc_pc_held", S_PC, 32'h300);
        end
        1: begin
          clear_ctrl(); pc_write = 1'b1; src_sel = 2'd0;
          push("exc_vec_pc", S_PC, 32'h88); push("exc_in_hnd", S_HND, 32'h1);
          push("exc_ack_drop", S_ACK, 32'h0);
        end
        2: begin
          clear_ctrl(); eret = 1'b1;
          push("eret_pc", S_PC, 32'h300); push("eret_hnd", S_HND, 32'h0);
        end
        default: begin
          push("eret_run_ignored", S_PC, 32'h300);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
    clear_ctrl();
  endtask

  task automatic test_double_fault();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: begin
          exc_req = 1'b1; exc_cause = 2'd1;
          push("df_entry_epc", S_EPC, 32'h300); push("df_entry_cause", S_CAUSE, 32'h1);
        end
        1: begin
          clear_ctrl();
          push("df_vec_pc", S_PC, 32'h84);
        end
        2: begin
          pc_write = 1'b1; src_sel = 2'd3;
          push("hnd_load_pc", S_PC, 32'h400); push("hnd_load_stay", S_HND, 32'h1);
        end
        3: begin
          pc_write = 1'b0; exc_req = 1'b1; eret = 1'b1; exc_cause = 2'd3;
          push("df_flag", S_DF, 32'h1);      push("df_pc", S_PC, 32'h80);
          push("df_epc_kept", S_EPC, 32'h300); push("df_cause_kept", S_CAUSE, 32'h1);
          push("df_stay_hnd", S_HND, 32'h1);
        end
        4: begin
          clear_ctrl(); eret = 1'b1;
          push("df_eret_pc", S_PC, 32'h300); push("df_sticky_eret", S_DF, 32'h1);
        end
        5: begin
          clear_ctrl(); pc_write = 1'b1; src_sel = 2'd1;
          push("df_sticky_run", S_DF, 32'h1); push("df_run_load", S_PC, 32'h200);
        end
        6: begin
          clear_ctrl(); reset_n = 1'b0;
          push("df_cleared", S_DF, 32'h0); push("df_rst_pc", S_PC, 32'h0);
        end
        default: begin
          reset_n = 1'b1;
          push("df_post_rst", S_DF, 32'h0);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
    clear_ctrl();
  endtask

  task automatic test_simultaneous();
    exp_t e; logic [31:0] got;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          pc_write = 1'b1; src_sel = 2'd1; src_sel3 = 2'd3;
          push("sim_setup_pc", S_PC, 32'h200); push("sel_oob_src0", S_NEXT3, 32'h111);
        end
        1: begin
          pc_write = 1'b1; src_sel = 2'd3; exc_req = 1'b1; exc_cause = 2'd0; src_sel3 = 2'd2;
          push("sim_no_load", S_PC, 32'h200); push("sim_epc_old", S_EPC, 32'h200);
          push("sim_ack", S_ACK, 32'h1);      push("sim_cause", S_CAUSE, 32'h0);
          push("sel3_src2", S_NEXT3, 32'h333);
        end
        2: begin
          clear_ctrl();
          push("sim_vec_pc", S_PC, 32'h80); push("sim_hnd", S_HND, 32'h1);
        end
        3: begin
          eret = 1'b1;
          push("sim_eret_pc", S_PC, 32'h200);
        end
        default: begin
          clear_ctrl();
          push("sim_no_df", S_DF, 32'h0);
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
    clear_ctrl();
  endtask

  task automatic test_align();
    exp_t e; logic [31:0] got;
    src_data[2*W +: W] = 32'h302;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin
          src_sel = 2'd2; pc_write = 1'b1;
`ifdef PCNEXT_ALIGN_CHECK_EN
          push("al_misalign", S_MIS, 32'h1); push("al_ack", S_ACK, 32'h1);
          push("al_cause", S_CAUSE, 32'h3);  push("al_pc_held", S_PC, 32'h200);
          push("al_epc", S_EPC, 32'h200);
`else
          push("al_misalign_off", S_MIS, 32'h0); push("al_pc_unchecked", S_PC, 32'h302);
          push("al_no_ack", S_ACK, 32'h0);
`endif
        end
        1: begin
          clear_ctrl();
`ifdef PCNEXT_ALIGN_CHECK_EN
          push("al_vec_pc", S_PC, 32'h8C); push("al_hnd", S_HND, 32'h1);
`else
          push("al_hold_pc", S_PC, 32'h302); push("al_no_hnd", S_HND, 32'h0);
`endif
        end
        default: begin
          eret = 1'b1;
`ifdef PCNEXT_ALIGN_CHECK_EN
          push("al_eret_pc", S_PC, 32'h200);
`else
          push("al_eret_ignored", S_PC, 32'h302);
`endif
        end
      endcase
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front(); got = observe(e.sig); n_run++;
        if (got !== e.val) begin
          n_fail++; $display("FAIL %s: got 0x%0h want 0x%0h", e.name, got, e.val);
        end
      end
    end
    clear_ctrl();
    src_data[2*W +: W] = 32'h300;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    src_data  = {32'h400, 32'h300, 32'h200, 32'h100};
    src_data3 = {32'h333, 32'h222, 32'h111};
    test_reset();
    test_load();
    test_branch();
    test_exception();
    test_double_fault();
    test_simultaneous();
    test_align();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised program-counter unit for the multicycle core: N-way next-PC selection plus the PC register, conditional-branch write, exception entry with EPC/cause capture, return-from-exception and double-fault detection. It replaces the plain combinational PC source select. It sits between the datapath's candidate-target buses (ALU result, ALUOut, jump target and others) and the instruction-fetch address. Control comes from the main control FSM.

## Interface
Parameters:
- WIDTH, 32, PC and source data width (≥ 8).
- NUM_SRC, 4, number of candidate next-PC sources (2..16).
- SEL_W, 2, select width; set ≥ ceil(log2(NUM_SRC)).
- RESET_VECTOR, 0, PC value after reset.
- EXC_VECTOR, 32'h0000_0080, exception handler base.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- src_sel  in  SEL_W  next-PC source index.
- src_data  in  NUM_SRC*WIDTH  packed sources; source k is bits [k*WIDTH +: WIDTH].
- pc_write  in  1  unconditional PC load.
- pc_write_cond  in  1  load PC only if cond_true.
- cond_true  in  1  branch condition from ALU (e.g. zero flag).
- exc_req  in  1  exception request, level, sampled each edge.
- exc_cause  in  2  cause code accompanying exc_req.
- eret  in  1  return from exception.
- pc  out  WIDTH  current PC (registered).
- pc_next  out  WIDTH  selected source (combinational view).
- epc  out  WIDTH  exception PC (registered).
- cause  out  2  latched cause (registered).
- exc_ack  out  1  high during EXC_ENTRY cycle.
- in_handler  out  1  high in HANDLER state.
- double_fault  out  1  sticky double-fault flag.
- misalign  out  1  selected target has nonzero bits [1:0] (see Configuration).

## Operation
- pc_next = source[src_sel]. If src_sel ≥ NUM_SRC, pc_next = source 0.
- A load is taken when pc_write=1, or when pc_write_cond=1 and cond_true=1.
- FSM states: RUN, EXC_ENTRY, HANDLER.
- RUN:
  - exc_req=1 (or a taken load with misalign=1): epc ← pc, cause ← exc_cause (11 for misalign), go to EXC_ENTRY. PC is held.
  - Otherwise a taken load sets pc ← pc_next.
  - eret is ignored in RUN.
- EXC_ENTRY (exactly one cycle):
  - pc ← EXC_VECTOR + {cause, 2'b00}, then go to HANDLER.
  - All inputs are ignored.
- HANDLER:
  - Taken loads work as in RUN.
  - eret=1: pc ← epc, go to RUN.
  - exc_req=1: double_fault ← 1, pc ← EXC_VECTOR, stay in HANDLER. epc and cause are unchanged.
- Priority in each cycle: reset > exception/misalign > eret > load.
- Arithmetic: vector addition is modulo 2^WIDTH with no carry out. The cause offset is zero-extended.

## Timing
- Reset (reset_n=0 at an edge): pc=RESET_VECTOR, epc=0, cause=0, state=RUN, exc_ack=0, in_handler=0, double_fault=0.
  - misalign and pc_next remain combinational during reset.
  - Reset mid-exception aborts it immediately.
- Load latency: 1 edge. pc shows the new value in the cycle after the load is sampled.
- Exception latency: exc_req sampled at edge N → EXC_ENTRY in cycle N+1 (exc_ack=1). At edge N+1 pc becomes the vector, and in_handler=1 from cycle N+2.
- eret sampled at edge M → pc=epc and in_handler=0 from cycle M+1.
- pc_write and exc_req in the same cycle: the exception wins, no load occurs, and epc is the old pc.
- eret and exc_req together in HANDLER: the double fault wins.
- double_fault clears only on reset.

## Configuration
- PCNEXT_ALIGN_CHECK_EN defined:
  - misalign = |pc_next[1:0].
  - A taken load with misalign=1 is converted into an exception with cause 2'b11. pc is not updated with the bad target.
  - In HANDLER, the same event is a double fault.
- Not defined:
  - misalign is tied to 0.
  - The low bits of targets load unchecked.

## Test plan
- Reset with NUM_SRC=4 and sources {0x100, 0x200, 0x300, 0x400}: after release pc=0. Then src_sel=2 with pc_write → pc=0x300 next cycle.
- Conditional branch: pc_write_cond=1 with cond_true=0 → pc unchanged. With cond_true=1 and src_sel=1 → pc=0x200.
- Exception: pc=0x300, exc_req=1, exc_cause=2 → the next cycle has exc_ack=1 and epc=0x300. Then pc=0x88 and in_handler=1. eret → pc=0x300, in_handler=0.
- Double fault: exc_req in HANDLER → double_fault=1, pc=0x80, epc still 0x300. The flag stays set until reset_n=0.
- Simultaneous events: pc_write with exc_req in RUN → no load, epc=old pc. src_sel=3 with NUM_SRC=3 → pc_next=source 0.
- With PCNEXT_ALIGN_CHECK_EN: source 0x302 with pc_write → misalign=1, cause=3, pc=0x8C after entry. Without the macro: pc=0x302 and misalign=0.
